// File: rtl/shift_reg_univ.sv
// -----------------------------------------------------------------------------
// shift_reg_univ
//   Parametrised universal register. It supports hold, parallel load, logical
//   shift and rotate in both directions, and arithmetic shift right. It also
//   has an autonomous burst engine that applies one shift/rotate op N times.
//
// Ports
//   CLOCK     in   1      rising-edge clock
//   RESET     in   1      asynchronous, active-high reset
//   ENABLE    in   1      global clock enable; low freezes Q, FSM and counter
//   CLEAR     in   1      synchronous clear, wins over ENABLE
//   MODE      in   3      op select: 000 hold, 001 load, 010 SHL, 011 SHR,
//                         100 ROL, 101 ROR, 110 ASR, 111 hold
//   D         in   WIDTH  parallel load data
//   SIN_LSB   in   1      serial bit entering Q[0] on SHL
//   SIN_MSB   in   1      serial bit entering Q[WIDTH-1] on SHR
//   START     in   1      request a burst of NSHIFT steps of MODE
//   NSHIFT    in   CNT_W  burst length, clamped to WIDTH
//   Q         out  WIDTH  register contents
//   SOUT_MSB  out  1      Q[WIDTH-1]
//   SOUT_LSB  out  1      Q[0]
//   BUSY      out  1      high while a burst is in progress
//   DONE      out  1      one-cycle registered pulse on burst completion
//
// Burst handshake: START is sampled only in IDLE on an enabled edge with MODE
// in 010..110. It has no ready/ack. Acceptance is visible as BUSY=1 on the
// following cycle. For NSHIFT=0 there is no BUSY, only a DONE pulse. While
// BUSY=1, START, MODE and D are ignored. DONE pulses for exactly one cycle on
// the cycle after the edge that applied the last step. CLEAR/RESET abort a
// burst without a DONE pulse.
// -----------------------------------------------------------------------------
module shift_reg_univ #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CLEAR,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_LSB,
  input  logic             SIN_MSB,
  input  logic             START,
  input  logic [CNT_W-1:0] NSHIFT,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT_MSB,
  output logic             SOUT_LSB,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] burst_res;
  logic [CNT_W-1:0] nshift_clamp;
  logic             mode_is_shift;

  // Shared op decoder, used for single ops (live MODE) and burst steps
  // (latched op). Serial inputs are always live.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] din,
    input logic             sl,
    input logic             sm
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      3'b001:  res = din;
      3'b010:  res = {cur[WIDTH-2:0], sl};
      3'b011:  res = {sm, cur[WIDTH-1:1]};
      3'b100:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      3'b101:  res = {cur[0], cur[WIDTH-1:1]};
      3'b110:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: res = cur;
    endcase
    return res;
  endfunction

  always_comb begin
    single_res    = apply_op(MODE, q_q, D, SIN_LSB, SIN_MSB);
    burst_res     = apply_op(op_q, q_q, D, SIN_LSB, SIN_MSB);
    mode_is_shift = (MODE >= 3'b010) && (MODE <= 3'b110);
    nshift_clamp  = (NSHIFT > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : NSHIFT;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (CLEAR) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!ENABLE) begin
      // Paused: everything holds, except DONE. DONE is a single-cycle pulse.
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (START && mode_is_shift) begin
            // Accepting edge: Q holds. A zero-length burst completes at once.
            if (nshift_clamp == '0) begin
              done_q <= 1'b1;
            end else begin
              op_q    <= MODE;
              cnt_q   <= nshift_clamp;
              busy_q  <= 1'b1;
              state_q <= S_BURST;
            end
          end else begin
            q_q <= single_res;
          end
        end
        S_BURST: begin
          q_q   <= burst_res;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q        = q_q;
  assign SOUT_MSB = q_q[WIDTH-1];
  assign SOUT_LSB = q_q[0];
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
module tb_shift_reg_univ;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // ---------------- clock / reset ----------------
  logic             clock;
  logic             reset;
  logic             enable;
  logic             clear;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin_lsb;
  logic             sin_msb;
  logic             start;
  logic [CNT_W-1:0] nshift;
  logic [WIDTH-1:0] q;
  logic             sout_msb;
  logic             sout_lsb;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  shift_reg_univ #(.WIDTH(WIDTH)) dut (
    .CLOCK    (clock),
    .RESET    (reset),
    .ENABLE   (enable),
    .CLEAR    (clear),
    .MODE     (mode),
    .D        (d),
    .SIN_LSB  (sin_lsb),
    .SIN_MSB  (sin_msb),
    .START    (start),
    .NSHIFT   (nshift),
    .Q        (q),
    .SOUT_MSB (sout_msb),
    .SOUT_LSB (sout_lsb),
    .BUSY     (busy),
    .DONE     (done)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sl;
    logic             sm;
    logic             start;
    logic [WIDTH-1:0] exp_q;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [WIDTH-1:0] eq,
                         input logic eb, input logic ed);
    chk({name, " q"},    32'(q),    32'(eq));
    chk({name, " busy"}, 32'(busy), 32'(eb));
    chk({name, " done"}, 32'(done), 32'(ed));
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    mode  = 3'b001;
    d     = v;
    start = 1'b0;
    step();
    mode  = 3'b000;
  endtask

  task automatic kick(input logic [2:0] m, input logic [CNT_W-1:0] n);
    mode   = m;
    nshift = n;
    start  = 1'b1;
    step();
    start  = 1'b0;
    mode   = 3'b000;
  endtask

  // Global watchdog in case the stimulus itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int steps;
    int dones;

    vecs[0]  = '{3'b001, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[1]  = '{3'b010, 8'h00, 1'b1, 1'b0, 1'b0, 8'h4B};
    vecs[2]  = '{3'b101, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[3]  = '{3'b001, 8'h90, 1'b0, 1'b0, 1'b0, 8'h90};
    vecs[4]  = '{3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC8};
    vecs[5]  = '{3'b011, 8'h00, 1'b1, 1'b0, 1'b0, 8'h64};
    vecs[6]  = '{3'b111, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h64};
    vecs[7]  = '{3'b000, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h64};
    vecs[8]  = '{3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC8};
    vecs[9]  = '{3'b011, 8'h00, 1'b0, 1'b1, 1'b0, 8'hE4};
    vecs[10] = '{3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC8};
    vecs[11] = '{3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 8'hE4};
    vecs[12] = '{3'b001, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[13] = '{3'b101, 8'h00, 1'b1, 1'b1, 1'b0, 8'h1E};
    vecs[14] = '{3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C};
    // START with non-shift modes is ignored, and the op executes normally.
    vecs[15] = '{3'b001, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h5A};
    vecs[16] = '{3'b000, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h5A};

    reset   = 1'b1;
    enable  = 1'b1;
    clear   = 1'b0;
    mode    = 3'b001;
    d       = 8'hFF;
    sin_lsb = 1'b0;
    sin_msb = 1'b0;
    start   = 1'b0;
    nshift  = CNT_W'(3);
    step();
    step();
    chk_out("reset", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    mode  = 3'b000;

    // Single ops from the table.
    for (int i = 0; i < NV; i++) begin
      mode    = vecs[i].mode;
      d       = vecs[i].d;
      sin_lsb = vecs[i].sl;
      sin_msb = vecs[i].sm;
      start   = vecs[i].start;
      nshift  = CNT_W'(2);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_q, 1'b0, 1'b0);
      chk($sformatf("vec%0d sout_lsb", i), 32'(sout_lsb), 32'(vecs[i].exp_q[0]));
      chk($sformatf("vec%0d sout_msb", i), 32'(sout_msb), 32'(vecs[i].exp_q[WIDTH-1]));
    end
    start   = 1'b0;
    mode    = 3'b000;
    sin_lsb = 1'b0;
    sin_msb = 1'b0;

    // Burst ROL x3. Load mode with D=FF during the burst must be ignored.
    load(8'h01);
    kick(3'b100, CNT_W'(3));
    chk_out("b3 accept", 8'h01, 1'b1, 1'b0);
    mode = 3'b001;
    d    = 8'hFF;
    start = 1'b1;
    step();
    chk_out("b3 s1", 8'h02, 1'b1, 1'b0);
    step();
    chk_out("b3 s2", 8'h04, 1'b1, 1'b0);
    step();
    chk_out("b3 s3", 8'h08, 1'b0, 1'b1);
    mode  = 3'b000;
    start = 1'b0;
    step();
    chk_out("b3 after", 8'h08, 1'b0, 1'b0);

    // Burst with an ENABLE=0 pause of two cycles.
    load(8'h01);
    kick(3'b100, CNT_W'(3));
    chk_out("pz accept", 8'h01, 1'b1, 1'b0);
    step();
    chk_out("pz s1", 8'h02, 1'b1, 1'b0);
    enable = 1'b0;
    step();
    chk_out("pz hold1", 8'h02, 1'b1, 1'b0);
    step();
    chk_out("pz hold2", 8'h02, 1'b1, 1'b0);
    enable = 1'b1;
    dones = 0;
    step();
    chk_out("pz s2", 8'h04, 1'b1, 1'b0);
    step();
    chk_out("pz s3", 8'h08, 1'b0, 1'b1);
    dones += int'(done);
    step();
    dones += int'(done);
    step();
    dones += int'(done);
    chk("pz done count", 32'(dones), 32'd1);
    chk("pz final q", 32'(q), 32'h08);

    // CLEAR aborts a SHL burst of 5 after one step.
    load(8'h81);
    sin_lsb = 1'b1;
    kick(3'b010, CNT_W'(5));
    chk_out("clr accept", 8'h81, 1'b1, 1'b0);
    step();
    chk_out("clr s1", 8'h03, 1'b1, 1'b0);
    clear  = 1'b1;
    enable = 1'b0;
    step();
    chk_out("clr applied", 8'h00, 1'b0, 1'b0);
    clear   = 1'b0;
    enable  = 1'b1;
    sin_lsb = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      dones += int'(done) + int'(busy);
    end
    chk("clr no done/busy", 32'(dones), 32'd0);
    chk("clr q stays", 32'(q), 32'h00);

    // Zero-length burst: DONE pulse only, with Q unchanged.
    load(8'h5A);
    kick(3'b101, CNT_W'(0));
    chk_out("n0 pulse", 8'h5A, 1'b0, 1'b1);
    step();
    chk_out("n0 after", 8'h5A, 1'b0, 1'b0);

    // NSHIFT above WIDTH clamps to WIDTH: 8 rotations restore the value.
    load(8'h96);
    kick(3'b100, CNT_W'(15));
    chk_out("clamp accept", 8'h96, 1'b1, 1'b0);
    steps = 0;
    while (!done && steps < 20) begin
      step();
      steps++;
    end
    chk("clamp steps", 32'(steps), 32'd8);
    chk_out("clamp end", 8'h96, 1'b0, 1'b1);

    // Asynchronous reset between edges in the middle of a burst.
    load(8'h01);
    kick(3'b100, CNT_W'(5));
    step();
    chk_out("rst s1", 8'h02, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_out("rst async", 8'h00, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    load(8'h03);
    kick(3'b100, CNT_W'(2));
    chk_out("rst restart", 8'h03, 1'b1, 1'b0);
    step();
    chk_out("rst r1", 8'h06, 1'b1, 1'b0);
    step();
    chk_out("rst r2", 8'h0C, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
